// File: rtl/axi_uart_lite_slave_pkg.sv
// Shared definitions for the UART Lite register map: register indices,
// status bit positions, AXI response codes, FSM state types and a status
// word packing helper.
package uart_lite_pkg;

   localparam logic [1:0] RX_FIFO = 2'd0;
   localparam logic [1:0] TX_FIFO = 2'd1;
   localparam logic [1:0] STAT    = 2'd2;
   localparam logic [1:0] CTRL    = 2'd3;

   localparam int unsigned STAT_RX_VALID = 0;
   localparam int unsigned STAT_RX_FULL  = 1;
   localparam int unsigned STAT_TX_EMPTY = 2;
   localparam int unsigned STAT_TX_FULL  = 3;
   localparam int unsigned STAT_OVERRUN  = 5;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wr_state_t;
   typedef enum logic       {R_IDLE, R_RESP} rd_state_t;

   // Build the 32-bit status register word from the individual flags.
   function automatic logic [31:0] pack_status(input logic rx_valid, input logic rx_full,
                                               input logic tx_empty, input logic tx_full,
                                               input logic overrun);
      logic [31:0] s;
      s                = '0;
      s[STAT_RX_VALID] = rx_valid;
      s[STAT_RX_FULL]  = rx_full;
      s[STAT_TX_EMPTY] = tx_empty;
      s[STAT_TX_FULL]  = tx_full;
      s[STAT_OVERRUN]  = overrun;
      return s;
   endfunction

endpackage

// File: rtl/axi_uart_lite_slave_if.sv
// AXI4-lite bus bundle for the UART Lite responder.
// Ports: AW/W/B/AR/R channel signals; master drives requests, slave responds.
interface axi_uart_lite_slave_if;
   logic        axi_awvalid;
   logic        axi_awready;
   logic [31:0] axi_awaddr;
   logic [2:0]  axi_awprot;
   logic        axi_wvalid;
   logic        axi_wready;
   logic [31:0] axi_wdata;
   logic [3:0]  axi_wstrb;
   logic        axi_bvalid;
   logic        axi_bready;
   logic [1:0]  axi_bresp;
   logic        axi_arvalid;
   logic        axi_arready;
   logic [31:0] axi_araddr;
   logic [2:0]  axi_arprot;
   logic        axi_rvalid;
   logic        axi_rready;
   logic [31:0] axi_rdata;
   logic [1:0]  axi_rresp;

   modport master (
      output axi_awvalid, axi_awaddr, axi_awprot, axi_wvalid, axi_wdata, axi_wstrb,
             axi_bready, axi_arvalid, axi_araddr, axi_arprot, axi_rready,
      input  axi_awready, axi_wready, axi_bvalid, axi_bresp, axi_arready,
             axi_rvalid, axi_rdata, axi_rresp
   );

   modport slave (
      input  axi_awvalid, axi_awaddr, axi_awprot, axi_wvalid, axi_wdata, axi_wstrb,
             axi_bready, axi_arvalid, axi_araddr, axi_arprot, axi_rready,
      output axi_awready, axi_wready, axi_bvalid, axi_bresp, axi_arready,
             axi_rvalid, axi_rdata, axi_rresp
   );
endinterface

// File: rtl/axi_uart_lite_slave_byte_fifo.sv
// byte_fifo: synchronous first-word-fall-through byte FIFO.
// Ports: clk, rst (sync, active-high), i_push/i_push_data, i_pop, i_clear,
//        o_head (0 when empty), o_empty, o_full.
module byte_fifo #(
   parameter int unsigned DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_push,
   input  logic [7:0] i_push_data,
   input  logic       i_pop,
   input  logic       i_clear,
   output logic [7:0] o_head,
   output logic       o_empty,
   output logic       o_full
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [7:0]    r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_nxt;
   logic          r_empty;
   logic          r_full;
   logic          w_pop;
   logic          w_push;

   // Pop only when data exists; a push on a full FIFO succeeds only alongside a pop.
   always_comb begin
      w_pop       = i_pop && !r_empty;
      w_push      = i_push && (!r_full || w_pop);
      w_count_nxt = r_count;
      if (w_push && !w_pop)
         w_count_nxt = r_count + CW'(1);
      else if (!w_push && w_pop)
         w_count_nxt = r_count - CW'(1);
   end

   // Pointer/count/flag state; clear has priority over push and pop.
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_empty <= 1'b1;
         r_full  <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == '0);
         r_full  <= (w_count_nxt == CW'(DEPTH));
      end
   end

   // Storage array.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_push_data;
   end

   assign o_head  = r_empty ? 8'h00 : r_mem[r_rptr];
   assign o_empty = r_empty;
   assign o_full  = r_full;
endmodule

// File: rtl/axi_uart_lite_slave.sv
// AXI4-lite responder exposing the UART Lite register map (RX 0x0, TX 0x4,
// status 0x8, control 0xC) over a byte-stream PHY.
// Ports: clk, rst (sync, active-high), s_axi (AXI4-lite slave modport),
//        rx_in_valid/rx_in_data (PHY receive strobe), tx_out_valid/
//        tx_out_data/tx_out_ready (PHY transmit handshake).
// Build option: AXI_UART_SLAVE_SLVERR_EN returns SLVERR for unmapped accesses.
module axi_uart_lite_slave
   import uart_lite_pkg::*;
#(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned ADDR_LSB = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   axi_uart_lite_slave_if.slave       s_axi,
   input  logic                       rx_in_valid,
   input  logic [7:0]                 rx_in_data,
   output logic                       tx_out_valid,
   output logic [7:0]                 tx_out_data,
   input  logic                       tx_out_ready
);
   wr_state_t   r_wstate, w_wstate_nxt;
   rd_state_t   r_rstate, w_rstate_nxt;
   logic [31:0] r_awaddr, r_wdata, r_rdata;
   logic [1:0]  r_bresp, r_rresp;
   logic        r_overrun;

   logic        w_awready, w_wready, w_wr_fire, w_wr_err;
   logic [31:0] w_wr_addr, w_wr_data;
   logic [1:0]  w_wr_idx;
   logic        w_tx_push, w_ctrl_wr, w_tx_clear, w_rx_clear;
   logic        w_arready, w_ar_fire, w_rd_err, w_rx_pop, w_stat_rd, w_ovr_set;
   logic [1:0]  w_rd_idx;
   logic [31:0] w_rd_data;
   logic [7:0]  w_rx_head;
   logic        w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
   logic        w_unused;

   // Write FSM state register.
   always_ff @(posedge clk) begin
      if (rst) r_wstate <= W_IDLE;
      else     r_wstate <= w_wstate_nxt;
   end

   // Write FSM next state: collect AW and W in either order, then respond.
   always_comb begin
      w_wstate_nxt = r_wstate;
      case (r_wstate)
         W_IDLE: begin
            if (s_axi.axi_awvalid && s_axi.axi_wvalid) w_wstate_nxt = W_RESP;
            else if (s_axi.axi_awvalid)                w_wstate_nxt = W_HAVE_A;
            else if (s_axi.axi_wvalid)                 w_wstate_nxt = W_HAVE_D;
         end
         W_HAVE_A: if (s_axi.axi_wvalid)  w_wstate_nxt = W_RESP;
         W_HAVE_D: if (s_axi.axi_awvalid) w_wstate_nxt = W_RESP;
         W_RESP:   if (s_axi.axi_bready)  w_wstate_nxt = W_IDLE;
         default:  w_wstate_nxt = W_IDLE;
      endcase
   end

   // Write FSM outputs: readies, and the action strobe with its effective address/data.
   always_comb begin
      w_awready = 1'b0;
      w_wready  = 1'b0;
      w_wr_fire = 1'b0;
      w_wr_addr = s_axi.axi_awaddr;
      w_wr_data = s_axi.axi_wdata;
      case (r_wstate)
         W_IDLE: begin
            w_awready = !rst;
            w_wready  = !rst;
            w_wr_fire = !rst && s_axi.axi_awvalid && s_axi.axi_wvalid;
         end
         W_HAVE_A: begin
            w_wready  = !rst;
            w_wr_fire = !rst && s_axi.axi_wvalid;
            w_wr_addr = r_awaddr;
         end
         W_HAVE_D: begin
            w_awready = !rst;
            w_wr_fire = !rst && s_axi.axi_awvalid;
            w_wr_data = r_wdata;
         end
         default: ;
      endcase
   end

   assign w_wr_idx = w_wr_addr[ADDR_LSB+1:ADDR_LSB];
   assign w_rd_idx = s_axi.axi_araddr[ADDR_LSB+1:ADDR_LSB];

`ifdef AXI_UART_SLAVE_SLVERR_EN
   assign w_wr_err = ((w_wr_addr & ~(32'(3) << ADDR_LSB)) != 32'h0) ||
                     (w_wr_idx == RX_FIFO) || (w_wr_idx == STAT);
   assign w_rd_err = ((s_axi.axi_araddr & ~(32'(3) << ADDR_LSB)) != 32'h0) ||
                     (w_rd_idx == TX_FIFO) || (w_rd_idx == CTRL);
`else
   assign w_wr_err = 1'b0;
   assign w_rd_err = 1'b0;
`endif

   assign w_tx_push  = w_wr_fire && !w_wr_err && (w_wr_idx == TX_FIFO);
   assign w_ctrl_wr  = w_wr_fire && !w_wr_err && (w_wr_idx == CTRL);
   assign w_tx_clear = w_ctrl_wr && w_wr_data[0];
   assign w_rx_clear = w_ctrl_wr && w_wr_data[1];

   // Capture whichever of AW/W arrives first, and the write response.
   always_ff @(posedge clk) begin
      if (w_awready && s_axi.axi_awvalid) r_awaddr <= s_axi.axi_awaddr;
      if (w_wready && s_axi.axi_wvalid)   r_wdata  <= s_axi.axi_wdata;
      if (rst)            r_bresp <= OKAY;
      else if (w_wr_fire) r_bresp <= w_wr_err ? SLVERR : OKAY;
   end

   // Read FSM state register.
   always_ff @(posedge clk) begin
      if (rst) r_rstate <= R_IDLE;
      else     r_rstate <= w_rstate_nxt;
   end

   // Read FSM next state.
   always_comb begin
      w_rstate_nxt = r_rstate;
      case (r_rstate)
         R_IDLE:  if (w_ar_fire) w_rstate_nxt = R_RESP;
         R_RESP:  if (s_axi.axi_rready) w_rstate_nxt = R_IDLE;
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   // Read FSM outputs and read-side effects (RX pop, status read).
   always_comb begin
      w_arready = (r_rstate == R_IDLE) && !rst;
      w_ar_fire = w_arready && s_axi.axi_arvalid;
      w_rx_pop  = w_ar_fire && !w_rd_err && (w_rd_idx == RX_FIFO) && !w_rx_empty;
      w_stat_rd = w_ar_fire && !w_rd_err && (w_rd_idx == STAT);
      w_rd_data = '0;
      if (!w_rd_err) begin
         case (w_rd_idx)
            RX_FIFO: w_rd_data = {24'h0, w_rx_head};
            STAT:    w_rd_data = pack_status(!w_rx_empty, w_rx_full, w_tx_empty,
                                             w_tx_full, r_overrun);
            default: w_rd_data = '0;
         endcase
      end
   end

   // Byte arriving on a full RX FIFO with no same-cycle pop is lost.
   assign w_ovr_set = rx_in_valid && w_rx_full && !w_rx_pop;

   // Read response registers and sticky overrun flag (set beats clear-on-read).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata   <= '0;
         r_rresp   <= OKAY;
         r_overrun <= 1'b0;
      end else begin
         if (w_ar_fire) begin
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_err ? SLVERR : OKAY;
         end
         if (w_ovr_set)      r_overrun <= 1'b1;
         else if (w_stat_rd) r_overrun <= 1'b0;
      end
   end

   byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (rx_in_valid),
      .i_push_data (rx_in_data),
      .i_pop       (w_rx_pop),
      .i_clear     (w_rx_clear),
      .o_head      (w_rx_head),
      .o_empty     (w_rx_empty),
      .o_full      (w_rx_full)
   );

   byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_tx_push),
      .i_push_data (w_wr_data[7:0]),
      .i_pop       (tx_out_ready),
      .i_clear     (w_tx_clear),
      .o_head      (tx_out_data),
      .o_empty     (w_tx_empty),
      .o_full      (w_tx_full)
   );

   assign tx_out_valid      = !w_tx_empty;
   assign s_axi.axi_awready = w_awready;
   assign s_axi.axi_wready  = w_wready;
   assign s_axi.axi_bvalid  = (r_wstate == W_RESP);
   assign s_axi.axi_bresp   = r_bresp;
   assign s_axi.axi_arready = w_arready;
   assign s_axi.axi_rvalid  = (r_rstate == R_RESP);
   assign s_axi.axi_rdata   = r_rdata;
   assign s_axi.axi_rresp   = r_rresp;

   // Bus fields that carry no meaning for this register map.
   assign w_unused = ^{s_axi.axi_awprot, s_axi.axi_arprot, s_axi.axi_wstrb,
                       w_wr_addr, w_wr_data, s_axi.axi_araddr};
endmodule

// File: tb/tb_axi_uart_lite_slave.sv
// Directed bench for axi_uart_lite_slave: a vector table of RX pushes and
// register reads, plus hand-written sequences for write ordering, stalls,
// FIFO clear, simultaneous push/pop on a full FIFO and mid-transaction reset.
module tb_axi_uart_lite_slave;
   localparam int OP_RX = 0;
   localparam int OP_RD = 1;
`ifdef AXI_UART_SLAVE_SLVERR_EN
   localparam logic [1:0] EXP_UNMAPPED = 2'b10;
`else
   localparam logic [1:0] EXP_UNMAPPED = 2'b00;
`endif

   typedef struct {
      int          op;
      logic [31:0] addr;
      logic [7:0]  data;
      logic [31:0] exp;
      logic [1:0]  exp_resp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_in_valid;
   logic [7:0] rx_in_data;
   logic       tx_out_valid;
   logic [7:0] tx_out_data;
   logic       tx_out_ready;
   int         tests = 0;
   int         fails = 0;
   vec_t       vecs[$];

   always #5 clk = ~clk;

   axi_uart_lite_slave_if axi_if ();

   axi_uart_lite_slave #(.DEPTH(16), .ADDR_LSB(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .s_axi        (axi_if),
      .rx_in_valid  (rx_in_valid),
      .rx_in_data   (rx_in_data),
      .tx_out_valid (tx_out_valid),
      .tx_out_data  (tx_out_data),
      .tx_out_ready (tx_out_ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void add(input int op, input logic [31:0] addr, input logic [7:0] data,
                               input logic [31:0] exp, input logic [1:0] resp);
      vec_t v;
      v.op = op; v.addr = addr; v.data = data; v.exp = exp; v.exp_resp = resp;
      vecs.push_back(v);
   endfunction

   task automatic rx_push(input logic [7:0] b);
      rx_in_valid = 1'b1;
      rx_in_data  = b;
      @(negedge clk);
      rx_in_valid = 1'b0;
   endtask

   // Called at a negedge; returns at a negedge with the channel idle.
   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int n = 0;
      axi_if.axi_araddr  = addr;
      axi_if.axi_arvalid = 1'b1;
      while (!axi_if.axi_arready && n < 20) begin @(negedge clk); n++; end
      chk("ar_accept", 32'(n < 20), 32'd1);
      @(negedge clk);
      axi_if.axi_arvalid = 1'b0;
      chk("rd_latency", 32'(axi_if.axi_rvalid), 32'd1);
      data = axi_if.axi_rdata;
      resp = axi_if.axi_rresp;
      axi_if.axi_rready = 1'b1;
      @(negedge clk);
      axi_if.axi_rready = 1'b0;
   endtask

   // lead = cycles between AW and W handshakes (0 = together).
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input int lead,
                            output logic [1:0] resp);
      int n = 0;
      axi_if.axi_awaddr  = addr;
      axi_if.axi_wdata   = data;
      axi_if.axi_awvalid = 1'b1;
      if (lead == 0) axi_if.axi_wvalid = 1'b1;
      while (!axi_if.axi_awready && n < 20) begin @(negedge clk); n++; end
      chk("aw_accept", 32'(n < 20), 32'd1);
      @(negedge clk);
      axi_if.axi_awvalid = 1'b0;
      if (lead != 0) begin
         repeat (lead - 1) @(negedge clk);
         axi_if.axi_wvalid = 1'b1;
         n = 0;
         while (!axi_if.axi_wready && n < 20) begin @(negedge clk); n++; end
         chk("w_accept", 32'(n < 20), 32'd1);
         @(negedge clk);
      end
      axi_if.axi_wvalid = 1'b0;
      chk("wr_latency", 32'(axi_if.axi_bvalid), 32'd1);
      resp = axi_if.axi_bresp;
      axi_if.axi_bready = 1'b1;
      @(negedge clk);
      axi_if.axi_bready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      logic [1:0]  r;

      // RX drain / underflow, then overflow of a 16-deep FIFO.
      for (int i = 0; i < 4; i++) add(OP_RX, 0, 8'(8'h11 * (i + 1)), 0, 0);
      for (int i = 0; i < 4; i++) add(OP_RD, 32'h0, 0, 32'(8'h11 * (i + 1)), 2'b00);
      add(OP_RD, 32'h0, 0, 32'h0, 2'b00);
      add(OP_RD, 32'h8, 0, 32'h4, 2'b00);
      for (int i = 0; i < 17; i++) add(OP_RX, 0, 8'(8'h80 + i), 0, 0);
      add(OP_RD, 32'h8, 0, 32'h27, 2'b00);
      add(OP_RD, 32'h8, 0, 32'h07, 2'b00);
      add(OP_RD, 32'h4, 0, 32'h0, EXP_UNMAPPED);
      add(OP_RD, 32'hC, 0, 32'h0, EXP_UNMAPPED);
      add(OP_RD, 32'h0, 0, 32'h80, 2'b00);

      rst = 1'b1;
      rx_in_valid = 1'b0; rx_in_data = '0; tx_out_ready = 1'b0;
      axi_if.axi_awvalid = 1'b0; axi_if.axi_awaddr = '0; axi_if.axi_awprot = '0;
      axi_if.axi_wvalid = 1'b0;  axi_if.axi_wdata = '0;  axi_if.axi_wstrb = '0;
      axi_if.axi_bready = 1'b0;  axi_if.axi_arvalid = 1'b0; axi_if.axi_araddr = '0;
      axi_if.axi_arprot = '0;    axi_if.axi_rready = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_awready", 32'(axi_if.axi_awready), 0);
      chk("rst_wready",  32'(axi_if.axi_wready), 0);
      chk("rst_arready", 32'(axi_if.axi_arready), 0);
      chk("rst_bvalid",  32'(axi_if.axi_bvalid), 0);
      chk("rst_rvalid",  32'(axi_if.axi_rvalid), 0);
      chk("rst_rdata",   axi_if.axi_rdata, 0);
      chk("rst_resps",   32'({axi_if.axi_bresp, axi_if.axi_rresp}), 0);
      chk("rst_txvalid", 32'(tx_out_valid), 0);
      chk("rst_txdata",  32'(tx_out_data), 0);
      rst = 1'b0;
      @(negedge clk);

      axi_read(32'h8, d, r);
      chk("init_status", d, 32'h4);
      chk("init_rresp", 32'(r), 0);

      foreach (vecs[i]) begin
         if (vecs[i].op == OP_RX) rx_push(vecs[i].data);
         else begin
            axi_read(vecs[i].addr, d, r);
            chk($sformatf("vec%0d_data", i), d, vecs[i].exp);
            chk($sformatf("vec%0d_resp", i), 32'(r), 32'(vecs[i].exp_resp));
         end
      end

      // TX write with AW two cycles ahead of W; PHY not ready yet.
      axi_write(32'h4, 32'h41, 2, r);
      chk("tx_bresp", 32'(r), 0);
      chk("tx_valid", 32'(tx_out_valid), 1);
      chk("tx_data", 32'(tx_out_data), 32'h41);
      tx_out_ready = 1'b1;
      @(negedge clk);
      tx_out_ready = 1'b0;
      chk("tx_popped", 32'(tx_out_valid), 0);
      axi_read(32'h8, d, r);
      chk("tx_status", d, 32'h5);

      // Read response stalled by rready low.
      axi_if.axi_araddr = 32'h0; axi_if.axi_arvalid = 1'b1;
      @(negedge clk);
      axi_if.axi_arvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("rstall_rvalid", 32'(axi_if.axi_rvalid), 1);
         chk("rstall_rdata", axi_if.axi_rdata, 32'h81);
         chk("rstall_arready", 32'(axi_if.axi_arready), 0);
         @(negedge clk);
      end
      axi_if.axi_rready = 1'b1;
      @(negedge clk);
      axi_if.axi_rready = 1'b0;
      chk("rstall_done", 32'(axi_if.axi_rvalid), 0);

      // Write response stalled by bready low.
      axi_if.axi_awaddr = 32'h4; axi_if.axi_wdata = 32'h55;
      axi_if.axi_awvalid = 1'b1; axi_if.axi_wvalid = 1'b1;
      @(negedge clk);
      axi_if.axi_awvalid = 1'b0; axi_if.axi_wvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("bstall_bvalid", 32'(axi_if.axi_bvalid), 1);
         chk("bstall_bresp", 32'(axi_if.axi_bresp), 0);
         chk("bstall_ready", 32'({axi_if.axi_awready, axi_if.axi_wready}), 0);
         chk("bstall_txdata", 32'(tx_out_data), 32'h55);
         @(negedge clk);
      end
      axi_if.axi_bready = 1'b1;
      @(negedge clk);
      axi_if.axi_bready = 1'b0;
      chk("bstall_done", 32'(axi_if.axi_bvalid), 0);

      // Clear both FIFOs while both hold data.
      axi_write(32'hC, 32'h3, 0, r);
      chk("clr_bresp", 32'(r), 0);
      chk("clr_txvalid", 32'(tx_out_valid), 0);
      axi_read(32'h8, d, r);
      chk("clr_status", d, 32'h4);
      axi_read(32'h0, d, r);
      chk("clr_rxdata", d, 32'h0);

      // Full RX FIFO: push and pop in the same cycle both succeed, no overrun.
      for (int i = 0; i < 16; i++) rx_push(8'(8'hA0 + i));
      rx_in_valid = 1'b1; rx_in_data = 8'hB0;
      axi_if.axi_araddr = 32'h0; axi_if.axi_arvalid = 1'b1;
      @(negedge clk);
      rx_in_valid = 1'b0; axi_if.axi_arvalid = 1'b0;
      chk("full_pp_rvalid", 32'(axi_if.axi_rvalid), 1);
      chk("full_pp_rdata", axi_if.axi_rdata, 32'hA0);
      axi_if.axi_rready = 1'b1;
      @(negedge clk);
      axi_if.axi_rready = 1'b0;
      axi_read(32'h8, d, r);
      chk("full_pp_status", d, 32'h7);

      // Reset during a pending read response.
      axi_if.axi_araddr = 32'h8; axi_if.axi_arvalid = 1'b1;
      @(negedge clk);
      axi_if.axi_arvalid = 1'b0;
      chk("mid_rst_rvalid_pre", 32'(axi_if.axi_rvalid), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_rvalid", 32'(axi_if.axi_rvalid), 0);
      chk("mid_rst_arready", 32'(axi_if.axi_arready), 0);
      rst = 1'b0;
      @(negedge clk);
      axi_read(32'h8, d, r);
      chk("mid_rst_status", d, 32'h4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
